route_sequencer: RTL and testbench

ROUTE_SEQUENCER -- requirements
Module: route_sequencer

---
 rtl/route_pkg.sv | 24 ++
 rtl/junction_detect.sv | 41 ++++
 rtl/route_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_route_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/route_pkg.sv
// route_pkg: shared types and constants for the route sequencer.
//   state_t      : sequencer states
//   MOTOR_*      : H-bridge direction codes {in1,in2,in3,in4}
//   ACT_*        : route action encodings carried by cmd_action
package route_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FOLLOW = 2'd1,
    TURN   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [3:0] MOTOR_FWD   = 4'b1001;
  localparam logic [3:0] MOTOR_RIGHT = 4'b0101;
  localparam logic [3:0] MOTOR_LEFT  = 4'b1010;
  localparam logic [3:0] MOTOR_STOP  = 4'b1111;

  localparam logic [1:0] ACT_STOP     = 2'b00;
  localparam logic [1:0] ACT_LEFT     = 2'b01;
  localparam logic [1:0] ACT_RIGHT    = 2'b10;
  localparam logic [1:0] ACT_STOP_ALT = 2'b11;

endpackage

// File: rtl/junction_detect.sv
// junction_detect: debounces the all-sensors-high pattern.
//   clk, rst  : clock, synchronous active-high reset
//   en        : detection enabled (held cleared/armed when low)
//   all_high  : lt1 & lt2 & lt3
//   junction  : one-cycle pulse on the DEBOUNCE_CYCLES-th consecutive
//               all-high cycle; re-armed only after a not-all-high cycle
module junction_detect #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic all_high,
  output logic junction
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LOAD = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] deb_q;
  logic          armed_q;

  // Pulse is combinational on the qualifying sample so the sequencer can
  // act on the same edge the Nth all-high cycle is sampled.
  assign junction = en && all_high && armed_q && (deb_q == '0);

  always_ff @(posedge clk) begin
    if (rst || !en || !all_high) begin
      deb_q   <= DEB_LOAD;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (deb_q == '0) begin
        armed_q <= 1'b0;
        deb_q   <= DEB_LOAD;
      end else begin
        deb_q <= deb_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_sequencer.sv
// route_sequencer: line-following route controller.
//   clk, rst            : clock, synchronous active-high reset
//   lt1, lt2, lt3       : line sensors (lt2 centre)
//   cmd_valid/cmd_ready : route command handshake
//   cmd_junctions       : junction index at which the action executes
//   cmd_action          : 00 stop, 01 left, 10 right, 11 stop
//   abort               : cancel current route (also clears fault)
//   in1..in4            : registered H-bridge direction bits
//   busy, done, fault   : status (done is a one-cycle pulse)
// Optional macro LOST_LINE_TIMEOUT_EN enables the line-lost timeout.
//
// state  | meaning
// IDLE   | motors stopped, accepting commands
// FOLLOW | steering on line, counting junctions
// TURN   | driving the turn, waiting for timer then re-acquire
// FAULT  | line lost, motors stopped until abort or rst
module route_sequencer import route_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TURN_CYCLES     = 64,
  parameter int LOST_CYCLES     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lt1,
  input  logic       lt2,
  input  logic       lt3,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_junctions,
  input  logic [1:0] cmd_action,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    motor_q, motor_d;
  logic          done_q, done_d;
  logic [3:0]    jcnt_q, jcnt_d, jnext;
  logic [3:0]    target_q, target_d;
  logic [1:0]    action_q, action_d;
  logic [TW-1:0] turn_q, turn_d;
  logic          jpulse;
  logic          centred;

`ifdef LOST_LINE_TIMEOUT_EN
  localparam int LW = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
  localparam logic [LW-1:0] LOST_LOAD = LW'(LOST_CYCLES - 1);
  logic [LW-1:0] lost_q, lost_d;
`endif

  junction_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_junction_detect (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == FOLLOW),
    .all_high (lt1 & lt2 & lt3),
    .junction (jpulse)
  );

  assign centred   = lt2 & ~lt1 & ~lt3;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == FOLLOW) || (state_q == TURN);
  assign done      = done_q;
  assign {in1, in2, in3, in4} = motor_q;

`ifdef LOST_LINE_TIMEOUT_EN
  assign fault = (state_q == FAULT);
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    motor_d  = motor_q;
    done_d   = 1'b0;
    jcnt_d   = jcnt_q;
    target_d = target_q;
    action_d = action_q;
    turn_d   = turn_q;
    jnext    = (jcnt_q == 4'hF) ? 4'hF : jcnt_q + 4'd1;
`ifdef LOST_LINE_TIMEOUT_EN
    lost_d   = LOST_LOAD;
`endif

    case (state_q)
      IDLE: begin
        motor_d = MOTOR_STOP;
        if (cmd_valid) begin
          if (cmd_junctions == 4'd0) begin
            done_d = 1'b1;
          end else begin
            state_d  = FOLLOW;
            target_d = cmd_junctions;
            action_d = cmd_action;
            jcnt_d   = 4'd0;
          end
        end
      end
      FOLLOW: begin
        if (lt2)      motor_d = MOTOR_FWD;
        else if (lt1) motor_d = MOTOR_RIGHT;
        else if (lt3) motor_d = MOTOR_LEFT;
        if (jpulse) begin
          jcnt_d = jnext;
          if (jnext == target_q) begin
            if (action_q == ACT_LEFT) begin
              state_d = TURN;
              motor_d = MOTOR_LEFT;
              turn_d  = TURN_LOAD;
            end else if (action_q == ACT_RIGHT) begin
              state_d = TURN;
              motor_d = MOTOR_RIGHT;
              turn_d  = TURN_LOAD;
            end else begin
              state_d = IDLE;
              motor_d = MOTOR_STOP;
              done_d  = 1'b1;
            end
          end
        end
      end
      TURN: begin
        if (turn_q == '0) begin
          if (centred) begin
            state_d = IDLE;
            motor_d = MOTOR_STOP;
            done_d  = 1'b1;
          end
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      FAULT: motor_d = MOTOR_STOP;
      default: begin
        state_d = IDLE;
        motor_d = MOTOR_STOP;
      end
    endcase

`ifdef LOST_LINE_TIMEOUT_EN
    // Completion needs a sensor high, so it never coincides with a timeout.
    if ((state_q == FOLLOW) || (state_q == TURN)) begin
      if (lt1 | lt2 | lt3) begin
        lost_d = LOST_LOAD;
      end else if (lost_q == '0) begin
        state_d = FAULT;
        motor_d = MOTOR_STOP;
        done_d  = 1'b0;
      end else begin
        lost_d = lost_q - 1'b1;
      end
    end
`endif

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      motor_d = MOTOR_STOP;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      motor_q  <= MOTOR_STOP;
      done_q   <= 1'b0;
      jcnt_q   <= 4'd0;
      target_q <= 4'd0;
      action_q <= ACT_STOP;
      turn_q   <= '0;
`ifdef LOST_LINE_TIMEOUT_EN
      lost_q   <= LOST_LOAD;
`endif
    end else begin
      state_q  <= state_d;
      motor_q  <= motor_d;
      done_q   <= done_d;
      jcnt_q   <= jcnt_d;
      target_q <= target_d;
      action_q <= action_d;
      turn_q   <= turn_d;
`ifdef LOST_LINE_TIMEOUT_EN
      lost_q   <= lost_d;
`endif
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// tb_route_sequencer: directed self-checking bench for route_sequencer
// with default parameters (8/64/256).
module tb_route_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lt1 = 1'b0, lt2 = 1'b0, lt3 = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_junctions = 4'd0;
  logic [1:0] cmd_action = 2'd0;
  logic       abort = 1'b0;
  logic       in1, in2, in3, in4;
  logic       busy, done, fault;
  logic [3:0] motor;

  localparam logic [3:0] M_FWD   = 4'b1001;
  localparam logic [3:0] M_RIGHT = 4'b0101;
  localparam logic [3:0] M_LEFT  = 4'b1010;
  localparam logic [3:0] M_STOP  = 4'b1111;

  int n_tests = 0;
  int n_fail  = 0;

  assign motor = {in1, in2, in3, in4};

  route_sequencer dut (
    .clk(clk), .rst(rst), .lt1(lt1), .lt2(lt2), .lt3(lt3),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_junctions(cmd_junctions), .cmd_action(cmd_action),
    .abort(abort), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input logic [2:0] s);
    {lt1, lt2, lt3} = s;
  endtask

  task automatic send_cmd(input logic [3:0] j, input logic [1:0] a);
    cmd_valid = 1'b1; cmd_junctions = j; cmd_action = a;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic burst_follow(input int len, input logic [3:0] exp_m);
    set_s(3'b111);
    for (int i = 0; i < len; i++) begin
      tick();
      check_eq("burst_motor", motor, exp_m);
      check_eq("burst_busy", busy, 1'b1);
      check_eq("burst_no_done", done, 1'b0);
    end
    set_s(3'b010);
    tick();
  endtask

  initial begin
    // reset state
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_motor", motor, M_STOP);
    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_fault", fault, 1'b0);
    tick();
    check_eq("idle_motor", motor, M_STOP);

    // cmd 2/stop, two 10-cycle bursts
    set_s(3'b010);
    send_cmd(4'd2, 2'b00);
    check_eq("a_busy", busy, 1'b1);
    check_eq("a_ready", cmd_ready, 1'b0);
    tick(); tick();
    check_eq("a_fwd", motor, M_FWD);
    burst_follow(10, M_FWD);
    tick(); tick();
    set_s(3'b111);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        check_eq("a_b2_done", done, 1'b0);
        check_eq("a_b2_motor", motor, M_FWD);
      end
    end
    check_eq("a_done", done, 1'b1);
    check_eq("a_stop", motor, M_STOP);
    check_eq("a_idle", busy, 1'b0);
    set_s(3'b010);
    tick();
    check_eq("a_done_pulse", done, 1'b0);
    check_eq("a_ready_after", cmd_ready, 1'b1);

    // zero-junction command: done without motion
    send_cmd(4'd0, 2'b01);
    check_eq("z_done", done, 1'b1);
    check_eq("z_busy", busy, 1'b0);
    check_eq("z_motor", motor, M_STOP);
    tick();
    check_eq("z_done_pulse", done, 1'b0);

    // cmd 1/stop: steering, short bursts, ignored command, 7 then 8 burst
    set_s(3'b010);
    send_cmd(4'd1, 2'b11);
    set_s(3'b100); tick();
    check_eq("s_right", motor, M_RIGHT);
    set_s(3'b001); tick();
    check_eq("s_left", motor, M_LEFT);
    set_s(3'b000); tick();
    check_eq("s_hold", motor, M_LEFT);
    set_s(3'b110); tick();
    check_eq("s_prio", motor, M_FWD);
    set_s(3'b010); tick();
    cmd_valid = 1'b1; cmd_junctions = 4'd2; cmd_action = 2'b01;
    tick();
    cmd_valid = 1'b0;
    for (int r = 0; r < 3; r++) burst_follow(5, M_FWD);
    burst_follow(7, M_FWD);
    check_eq("b_busy", busy, 1'b1);
    set_s(3'b111);
    for (int i = 0; i < 8; i++) tick();
    check_eq("b_done", done, 1'b1);
    check_eq("b_stop", motor, M_STOP);
    set_s(3'b010);
    tick();

    // cmd 1/left: burst, 100 cycles lost, re-acquire
    send_cmd(4'd1, 2'b01);
    tick();
    set_s(3'b111);
    for (int i = 0; i < 8; i++) tick();
    check_eq("c_left", motor, M_LEFT);
    check_eq("c_busy", busy, 1'b1);
    tick(); tick();
    set_s(3'b000);
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("c_hold_left", motor, M_LEFT);
    end
    set_s(3'b010);
    tick();
    check_eq("c_done", done, 1'b1);
    check_eq("c_stop", motor, M_STOP);
    check_eq("c_idle", cmd_ready, 1'b1);
    tick();

    // cmd 1/right: re-acquire sensor present immediately, minimum turn time
    send_cmd(4'd1, 2'b10);
    tick();
    set_s(3'b111);
    for (int i = 0; i < 8; i++) tick();
    check_eq("d_right", motor, M_RIGHT);
    set_s(3'b010);
    for (int i = 1; i <= 63; i++) begin
      tick();
      check_eq("d_min_turn", {done, motor}, {1'b0, M_RIGHT});
    end
    tick();
    check_eq("d_done", done, 1'b1);
    check_eq("d_stop", motor, M_STOP);
    tick();

    // abort on the target junction cycle
    send_cmd(4'd1, 2'b00);
    tick();
    set_s(3'b111);
    for (int i = 0; i < 7; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("e_no_done", done, 1'b0);
    check_eq("e_stop", motor, M_STOP);
    check_eq("e_idle", cmd_ready, 1'b1);
    set_s(3'b010);
    tick();
    check_eq("e_no_done_late", done, 1'b0);

    // rst mid-route overrides abort and cmd_valid
    send_cmd(4'd3, 2'b01);
    tick();
    check_eq("r_busy", busy, 1'b1);
    rst = 1'b1; abort = 1'b1; cmd_valid = 1'b1; cmd_junctions = 4'd2;
    tick();
    rst = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    check_eq("r_idle", busy, 1'b0);
    check_eq("r_done", done, 1'b0);
    check_eq("r_motor", motor, M_STOP);
    tick();

    // line lost timeout
    set_s(3'b000);
    send_cmd(4'd3, 2'b00);
`ifdef LOST_LINE_TIMEOUT_EN
    for (int i = 1; i <= 255; i++) tick();
    check_eq("f_not_yet", fault, 1'b0);
    tick();
    check_eq("f_fault", fault, 1'b1);
    check_eq("f_stop", motor, M_STOP);
    check_eq("f_busy", busy, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("f_cleared", fault, 1'b0);
    check_eq("f_idle", cmd_ready, 1'b1);
`else
    for (int i = 0; i < 300; i++) tick();
    check_eq("f_no_fault", fault, 1'b0);
    check_eq("f_still_busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("f_idle", cmd_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
